// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system-bus arbiter:
// FSM state encoding, master IDs, default bus widths and a
// counter-width helper for the timeout counter.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Bits needed to hold 0 .. t-1 (at least one bit).
  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Transfer timeout counter. Cleared when a transfer is granted, counts
// once per BUSY cycle, and flags terminal count when it reaches TIMEOUT-1.
module arb_timeout_cnt
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk1,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW     = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Clear has priority; the arbiter leaves BUSY at terminal count, so no wrap.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master / one-slave round-robin bus arbiter with req/ack sequencing
// and a per-transfer timeout.
// Optional feature: define ARB_LOCK_EN to let m0_lock keep the grant with
// master 0 across consecutive transfers; otherwise m0_lock is ignored.
//
// Handshake: a master raises mX_req with a stable payload and holds both
// until its one-cycle mX_done pulse (mX_err qualifies it). The slave sees
// s_req held high for the whole transfer and answers with a one-cycle
// s_ack; if s_ack does not arrive within TIMEOUT cycles the transfer is
// aborted with err = 1 and m_rdata = 0.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  input  logic              m0_lock,
  output logic              grant
);

  arb_state_t        r_state;
  logic              r_last;
  logic              r_grant;
  logic              r_s_req;
  logic              r_s_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdata;
  logic [DATA_W-1:0] r_m_rdata;
  logic              r_m0_done;
  logic              r_m1_done;
  logic              r_m0_err;
  logic              r_m1_err;

  logic w_any_req;
  logic w_pick_m1;
  logic w_lock_hold;
  logic w_tc;
  logic w_cnt_clr;
  logic w_cnt_en;

`ifdef ARB_LOCK_EN
  // Master 0 keeps priority while it holds the lock and owned the last grant.
  assign w_lock_hold = m0_lock & (r_last == M0);
`else
  logic w_unused_lock;
  assign w_unused_lock = m0_lock;
  assign w_lock_hold   = 1'b0;
`endif

  // Winner selection: a lone requester wins; on contention the master that
  // did not own the last grant wins, unless master 0 is holding the lock.
  assign w_any_req = m0_req | m1_req;
  assign w_pick_m1 = m1_req & (~m0_req | ((r_last == M0) & ~w_lock_hold));

  // Counter restarts on every grant and runs only while a transfer is open.
  assign w_cnt_clr = (r_state == IDLE) & w_any_req;
  assign w_cnt_en  = (r_state == BUSY);

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk1  (clk1),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Arbitration FSM: grant and latch payload in IDLE, wait for ack or
  // timeout in BUSY; done/err are one-cycle registered pulses.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last    <= M1;
      r_grant   <= M0;
      r_s_req   <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_rdata <= '0;
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      r_m0_err  <= 1'b0;
      r_m1_err  <= 1'b0;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      r_m0_err  <= 1'b0;
      r_m1_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= BUSY;
            r_s_req   <= 1'b1;
            r_grant   <= w_pick_m1;
            r_last    <= w_pick_m1;
            r_s_we    <= w_pick_m1 ? m1_we    : m0_we;
            r_s_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
            r_s_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
          end
        end
        BUSY: begin
          if (s_ack) begin
            // Ack wins over a simultaneous timeout.
            r_state   <= IDLE;
            r_s_req   <= 1'b0;
            r_m_rdata <= s_rdata;
            r_m0_done <= (r_grant == M0);
            r_m1_done <= (r_grant == M1);
          end else if (w_tc) begin
            r_state   <= IDLE;
            r_s_req   <= 1'b0;
            r_m_rdata <= '0;
            r_m0_done <= (r_grant == M0);
            r_m1_done <= (r_grant == M1);
            r_m0_err  <= (r_grant == M0);
            r_m1_err  <= (r_grant == M1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m0_done = r_m0_done;
  assign m0_err  = r_m0_err;
  assign m1_done = r_m1_done;
  assign m1_err  = r_m1_err;
  assign m_rdata = r_m_rdata;
  assign s_req   = r_s_req;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign grant   = r_grant;

endmodule
